// File: rtl/riscv_l2_arb_pkg.sv
// Shared types, defaults and helpers for the L2 port arbiter.
package riscv_l2_arb_pkg;

    // Arbiter FSM: IDLE picks a winner, BUSY owns the L2 port until ready/timeout.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int unsigned DEFAULT_ADDR_W = 64;
    localparam int unsigned DEFAULT_DATA_W = 64;

    // Width of an index able to address n items; never narrower than one bit.
    function automatic int unsigned port_idx_w(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/riscv_rr_arbiter.sv
// Combinational round-robin priority rotate: first request at or above ptr wins.
module riscv_rr_arbiter
    import riscv_l2_arb_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]               req,
    input  logic [port_idx_w(N)-1:0]   ptr,
    output logic [N-1:0]               grant_onehot,
    output logic [port_idx_w(N)-1:0]   grant_idx
);

    localparam int unsigned IdxW = port_idx_w(N);

    logic              found;
    int unsigned       pos;
    logic [IdxW-1:0]   pos_idx;

    // Scan N positions starting at ptr, wrapping modulo N; keep the first hit.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        pos          = 0;
        pos_idx      = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = 32'(ptr) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_idx = IdxW'(pos);
            if (!found && req[pos_idx]) begin
                found                 = 1'b1;
                grant_onehot[pos_idx] = 1'b1;
                grant_idx             = pos_idx;
            end
        end
    end

endmodule

// File: rtl/riscv_l2_port_arbiter.sv
// Shares one L2 request port among NUM_PORTS L1 requesters with round-robin
// fairness and a watchdog that returns an error response if L2 never answers.
module riscv_l2_port_arbiter
    import riscv_l2_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS      = 2,
    parameter int unsigned ADDR_W         = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W         = DEFAULT_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS-1:0]          req_valid,
    input  logic [NUM_PORTS-1:0]          req_write,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
    output logic [NUM_PORTS-1:0]          req_ready,
    output logic [NUM_PORTS-1:0]          resp_valid,
    output logic [DATA_W-1:0]             resp_rdata,
    output logic                          resp_err,
    output logic [ADDR_W-1:0]             l2_addr,
    output logic                          l2_read,
    output logic                          l2_write,
    output logic [DATA_W-1:0]             l2_wdata,
    input  logic [DATA_W-1:0]             l2_rdata,
    input  logic                          l2_ready
);

    localparam int unsigned IdxW = port_idx_w(NUM_PORTS);
    localparam int unsigned CntW = port_idx_w(TIMEOUT_CYCLES);

    arb_state_e          state_q, state_d;
    logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]     grant_q, grant_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [NUM_PORTS-1:0] resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;

    logic [NUM_PORTS-1:0] win_onehot;
    logic [IdxW-1:0]      win_idx;
    logic [NUM_PORTS-1:0] grant_q_onehot;
    logic [IdxW-1:0]      next_ptr;
    logic                 timed_out;

    logic [ADDR_W-1:0] addr_arr  [NUM_PORTS];
    logic [DATA_W-1:0] wdata_arr [NUM_PORTS];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
        assign addr_arr[p]  = req_addr[p*ADDR_W +: ADDR_W];
        assign wdata_arr[p] = req_wdata[p*DATA_W +: DATA_W];
    end

    riscv_rr_arbiter #(
        .N (NUM_PORTS)
    ) u_rr_arbiter (
        .req          (req_valid),
        .ptr          (rr_ptr_q),
        .grant_onehot (win_onehot),
        .grant_idx    (win_idx)
    );

    // Decode the owning port and the pointer that follows it.
    always_comb begin
        grant_q_onehot          = '0;
        grant_q_onehot[grant_q] = 1'b1;
        next_ptr  = (grant_q == IdxW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
        timed_out = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    end

    // Next-state: grant in IDLE, finish on l2_ready or watchdog expiry in BUSY.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = '0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_d = win_idx;
                    write_d = req_write[win_idx];
                    addr_d  = addr_arr[win_idx];
                    wdata_d = wdata_arr[win_idx];
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (l2_ready) begin
                    // A ready on the watchdog's last cycle still counts as success.
                    resp_valid_d = grant_q_onehot;
                    resp_rdata_d = write_q ? '0 : l2_rdata;
                    rr_ptr_d     = next_ptr;
                    state_d      = IDLE;
                end else if (timed_out) begin
                    resp_valid_d = grant_q_onehot;
                    resp_err_d   = 1'b1;
                    rr_ptr_d     = next_ptr;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched request and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Outputs; req_ready is gated by rst_n so nothing is accepted while held in reset.
    always_comb begin
        req_ready  = (state_q == IDLE && rst_n) ? win_onehot : '0;
        l2_read    = (state_q == BUSY) && !write_q;
        l2_write   = (state_q == BUSY) && write_q;
        l2_addr    = addr_q;
        l2_wdata   = wdata_q;
        resp_valid = resp_valid_q;
        resp_rdata = resp_rdata_q;
        resp_err   = resp_err_q;
    end

endmodule
